// File: rtl/inj_cycle_scheduler_pkg.sv
// Shared types and helpers for the injection cycle scheduler: phase type,
// FSM state encoding and a saturating counter add.
package seq_sched_pkg;

  localparam int PHASE_W = 8;
  localparam int CNT_W   = 16;

  typedef logic [PHASE_W-1:0] phase_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, v} + {1'b0, n};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/inj_cycle_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above rr_ptr, with wrap.
module rr_arbiter #(
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] rr_ptr,
  output logic             any,
  output logic [SEL_W-1:0] index
);

  // Scan from the farthest candidate down so the nearest requester writes last.
  always_comb begin
    int c;
    any   = 1'b0;
    index = {SEL_W{1'b0}};
    c     = 0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      c     = (int'(rr_ptr) + k) % N_CH;
      index = req[c] ? SEL_W'(c) : index;
      any   = any | req[c];
    end
  end

endmodule

// File: rtl/inj_cycle_scheduler.sv
// Window sequencer and injection arbiter for N_CH predictors.
// Optional stats counters (grant_cnt, ovf_cnt) are built when INJ_CYCLE_STATS_EN is defined.
module inj_cycle_scheduler
  import seq_sched_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int PERIOD = 256,
  parameter int SEL_W  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [N_CH-1:0]       spike_in,
  output logic                  cycle_start,
  output logic [8*N_CH-1:0]     actual_phase,
  output logic [N_CH-1:0]       fired,
  input  logic [N_CH-1:0]       force_valid_in,
  input  logic [8*N_CH-1:0]     force_pred_in,
  output logic                  l2_wr_valid,
  input  logic                  l2_wr_ready,
  output logic [SEL_W-1:0]      l2_wr_sel,
  output logic [7:0]            l2_wr_data,
  output logic                  busy,
  output logic [15:0]           grant_cnt,
  output logic [15:0]           ovf_cnt
);

  sched_state_t                   state_q, state_d;
  phase_t                         phase_q, phase_d;
  logic [N_CH-1:0]                seen_q, seen_d;
  logic [N_CH-1:0][PHASE_W-1:0]   first_ph_q, first_ph_d;
  logic                           cs_q, cs_d;
  logic [N_CH-1:0]                fired_q, fired_d;
  logic [N_CH-1:0][PHASE_W-1:0]   aphase_q, aphase_d;

  logic [N_CH-1:0]                fv_prev_q;
  logic [N_CH-1:0][PHASE_W-1:0]   slot_q, slot_d, shadow_q, shadow_d;
  logic [N_CH-1:0]                pend_q, pend_d, shadow_v_q, shadow_v_d;
  logic                           valid_q, valid_d;
  logic [SEL_W-1:0]               sel_q, sel_d, rr_q, rr_d;
  logic [PHASE_W-1:0]             data_q, data_d;

  logic [N_CH-1:0]                rise_s, on_port_s;
  logic                           accept_s, arb_any_s;
  logic [SEL_W-1:0]               arb_idx_s;

  rr_arbiter #(.N_CH(N_CH), .SEL_W(SEL_W)) u_arb (
    .req    (pend_q),
    .rr_ptr (rr_q),
    .any    (arb_any_s),
    .index  (arb_idx_s)
  );

  // Window FSM, phase counter, first-spike capture and window-close outputs.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    seen_d     = seen_q;
    first_ph_d = first_ph_q;
    cs_d       = 1'b0;
    fired_d    = fired_q;
    aphase_d   = aphase_q;
    case (state_q)
      IDLE: begin
        phase_d = '0;
        seen_d  = '0;
        state_d = enable ? RUN : IDLE;
      end
      RUN: begin
        for (int i = 0; i < N_CH; i++) begin
          first_ph_d[i] = (spike_in[i] && !seen_q[i]) ? phase_q : first_ph_q[i];
          seen_d[i]     = seen_q[i] | spike_in[i];
        end
        if (phase_q == phase_t'(PERIOD - 1)) begin
          cs_d    = 1'b1;
          fired_d = seen_q | spike_in;
          // A spike only on the wrap edge reports the last phase of the window.
          for (int i = 0; i < N_CH; i++) begin
            aphase_d[i] = seen_q[i] ? first_ph_q[i] :
                          (spike_in[i] ? phase_t'(PERIOD - 1) : phase_t'(0));
          end
          phase_d = '0;
          seen_d  = '0;
          state_d = enable ? RUN : IDLE;
        end else begin
          phase_d = phase_q + 8'd1;
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
        seen_d  = '0;
      end
    endcase
  end

  assign rise_s   = force_valid_in & ~fv_prev_q;
  assign accept_s = valid_q & l2_wr_ready;

  // Injection capture into slots/shadows, round-robin grant and handshake.
  always_comb begin
    slot_d     = slot_q;
    pend_d     = pend_q;
    shadow_d   = shadow_q;
    shadow_v_d = shadow_v_q;
    valid_d    = valid_q;
    sel_d      = sel_q;
    data_d     = data_q;
    rr_d       = rr_q;
    for (int i = 0; i < N_CH; i++) begin
      on_port_s[i] = valid_q && (sel_q == SEL_W'(i));
      case ({rise_s[i], on_port_s[i]})
        2'b11: begin
          shadow_d[i]   = force_pred_in[PHASE_W*i +: PHASE_W];
          shadow_v_d[i] = 1'b1;
        end
        2'b10: begin
          slot_d[i] = force_pred_in[PHASE_W*i +: PHASE_W];
          pend_d[i] = 1'b1;
        end
        default: begin
          slot_d[i] = slot_d[i];
        end
      endcase
    end
    if (accept_s) begin
      valid_d = 1'b0;
      rr_d    = (sel_q == SEL_W'(N_CH - 1)) ? {SEL_W{1'b0}} : sel_q + SEL_W'(1'b1);
      // A re-edge seen while on the port keeps the channel pending with the new data.
      if (shadow_v_d[sel_q]) begin
        slot_d[sel_q]     = shadow_d[sel_q];
        shadow_v_d[sel_q] = 1'b0;
      end else begin
        pend_d[sel_q] = 1'b0;
      end
    end else if (!valid_q && arb_any_s) begin
      valid_d = 1'b1;
      sel_d   = arb_idx_s;
      data_d  = slot_d[arb_idx_s];
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      seen_q     <= '0;
      first_ph_q <= '0;
      cs_q       <= 1'b0;
      fired_q    <= '0;
      aphase_q   <= '0;
      fv_prev_q  <= '0;
      slot_q     <= '0;
      pend_q     <= '0;
      shadow_q   <= '0;
      shadow_v_q <= '0;
      valid_q    <= 1'b0;
      sel_q      <= '0;
      data_q     <= '0;
      rr_q       <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      seen_q     <= seen_d;
      first_ph_q <= first_ph_d;
      cs_q       <= cs_d;
      fired_q    <= fired_d;
      aphase_q   <= aphase_d;
      fv_prev_q  <= force_valid_in;
      slot_q     <= slot_d;
      pend_q     <= pend_d;
      shadow_q   <= shadow_d;
      shadow_v_q <= shadow_v_d;
      valid_q    <= valid_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      rr_q       <= rr_d;
    end
  end

  assign cycle_start  = cs_q;
  assign actual_phase = aphase_q;
  assign fired        = fired_q;
  assign l2_wr_valid  = valid_q;
  assign l2_wr_sel    = sel_q;
  assign l2_wr_data   = data_q;
  assign busy         = (state_q != IDLE);

`ifdef INJ_CYCLE_STATS_EN
  logic [CNT_W-1:0] grant_q, grant_d, ovf_q, ovf_d;

  // Saturating statistics; each overwritten slot or shadow counts once.
  always_comb begin
    logic [CNT_W-1:0] ovf_n;
    ovf_n = '0;
    for (int i = 0; i < N_CH; i++) begin
      ovf_n = ovf_n + CNT_W'(rise_s[i] & (on_port_s[i] ? shadow_v_q[i] : pend_q[i]));
    end
    ovf_d   = sat_add(ovf_q, ovf_n);
    grant_d = accept_s ? sat_add(grant_q, CNT_W'(1'b1)) : grant_q;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= '0;
      ovf_q   <= '0;
    end else begin
      grant_q <= grant_d;
      ovf_q   <= ovf_d;
    end
  end

  assign grant_cnt = grant_q;
  assign ovf_cnt   = ovf_q;
`else
  assign grant_cnt = 16'd0;
  assign ovf_cnt   = 16'd0;
`endif

endmodule

// File: tb/tb_inj_cycle_scheduler.sv
// Self-checking bench for inj_cycle_scheduler (PERIOD=16, N_CH=4) with a
// behavioural window/injection model and directed plus randomized scenarios.
module tb_inj_cycle_scheduler;

  localparam int N  = 4;
  localparam int P  = 16;
  localparam int SW = 2;
`ifdef INJ_CYCLE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            enable = 1'b0;
  logic [N-1:0]    spike_in = '0;
  logic            cycle_start;
  logic [8*N-1:0]  actual_phase;
  logic [N-1:0]    fired;
  logic [N-1:0]    force_valid_in = '0;
  logic [8*N-1:0]  force_pred_in = '0;
  logic            l2_wr_valid;
  logic            l2_wr_ready = 1'b0;
  logic [SW-1:0]   l2_wr_sel;
  logic [7:0]      l2_wr_data;
  logic            busy;
  logic [15:0]     grant_cnt;
  logic [15:0]     ovf_cnt;

  int checks = 0;
  int errors = 0;

  inj_cycle_scheduler #(.N_CH(N), .PERIOD(P), .SEL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .spike_in(spike_in),
    .cycle_start(cycle_start), .actual_phase(actual_phase), .fired(fired),
    .force_valid_in(force_valid_in), .force_pred_in(force_pred_in),
    .l2_wr_valid(l2_wr_valid), .l2_wr_ready(l2_wr_ready), .l2_wr_sel(l2_wr_sel),
    .l2_wr_data(l2_wr_data), .busy(busy), .grant_cnt(grant_cnt), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: a window is 'running' at a phase; each channel remembers
  // its first spike (-1 = none). Injections are kept as per-channel pending
  // slots, a shadow for the channel on the port, and the offered transfer.
  bit           m_run;
  int           m_phase;
  int           m_first[N];
  bit           m_cs;
  bit [N-1:0]   m_fired;
  int           m_aph[N];
  bit [N-1:0]   m_fvp;
  bit           m_valid;
  int           m_sel, m_data, m_rr, m_grants, m_ovf;
  bit           m_pend[N];
  int           m_slot[N];
  bit           m_shv[N];
  int           m_sh[N];

  task automatic model_reset();
    m_run = 0; m_phase = 0; m_cs = 0; m_fired = '0; m_fvp = '0;
    m_valid = 0; m_sel = 0; m_data = 0; m_rr = 0; m_grants = 0; m_ovf = 0;
    for (int i = 0; i < N; i++) begin
      m_first[i] = -1; m_aph[i] = 0; m_pend[i] = 0; m_slot[i] = 0; m_shv[i] = 0; m_sh[i] = 0;
    end
  endtask

  task automatic model_step();
    bit [N-1:0] rise;
    bit         snap[N];
    bit         acc, found;
    int         c, lane;
    m_cs = 0;
    if (!m_run) begin
      if (enable) begin m_run = 1; m_phase = 0; end
    end else begin
      for (int i = 0; i < N; i++)
        if (spike_in[i] && m_first[i] < 0) m_first[i] = m_phase;
      if (m_phase == P - 1) begin
        m_cs = 1;
        for (int i = 0; i < N; i++) begin
          m_fired[i] = (m_first[i] >= 0);
          m_aph[i]   = m_fired[i] ? m_first[i] : 0;
          m_first[i] = -1;
        end
        m_phase = 0;
        if (!enable) m_run = 0;
      end else begin
        m_phase++;
      end
    end
    rise = force_valid_in & ~m_fvp;
    m_fvp = force_valid_in;
    snap = m_pend;
    acc = m_valid && l2_wr_ready;
    for (int i = 0; i < N; i++) begin
      if (rise[i]) begin
        lane = int'(force_pred_in[8*i +: 8]);
        if (m_valid && m_sel == i) begin
          if (m_shv[i]) m_ovf++;
          m_shv[i] = 1; m_sh[i] = lane;
        end else begin
          if (m_pend[i]) m_ovf++;
          m_pend[i] = 1; m_slot[i] = lane;
        end
      end
    end
    if (acc) begin
      m_grants++;
      m_rr = (m_sel + 1) % N;
      if (m_shv[m_sel]) begin m_slot[m_sel] = m_sh[m_sel]; m_shv[m_sel] = 0; end
      else m_pend[m_sel] = 0;
      m_valid = 0;
    end else if (!m_valid) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        c = (m_rr + k) % N;
        if (!found && snap[c]) begin
          found = 1; m_valid = 1; m_sel = c; m_data = m_slot[c];
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; spike_in = '0; force_valid_in = '0;
    force_pred_in = '0; l2_wr_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (cycle_start !== 1'b0) begin errors++; $display("FAIL reset_cs got %b exp 0", cycle_start); end
    checks++; if (actual_phase !== '0) begin errors++; $display("FAIL reset_phase got %h exp 0", actual_phase); end
    checks++; if (fired !== '0) begin errors++; $display("FAIL reset_fired got %b exp 0", fired); end
    checks++; if (l2_wr_valid !== 1'b0 || l2_wr_sel !== '0 || l2_wr_data !== 8'd0) begin
      errors++; $display("FAIL reset_port got v=%b s=%0d d=%0d exp 0", l2_wr_valid, l2_wr_sel, l2_wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (grant_cnt !== 16'd0 || ovf_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got g=%0d o=%0d exp 0", grant_cnt, ovf_cnt); end
    do_reset();
  endtask

  task automatic test_window();
    int win, n, first_cs;
    do_reset();
    enable = 1'b1; win = 0; first_cs = -1;
    for (n = 1; n <= 40; n++) begin
      spike_in = '0;
      spike_in[0] = m_run && (m_phase == 3 || m_phase == 9);
      spike_in[2] = m_run && ((win == 0 && m_phase == 15) || (win == 1 && m_phase == 0));
      cyc();
      checks++; if (cycle_start !== m_cs) begin errors++; $display("FAIL win_cs n=%0d got %b exp %b", n, cycle_start, m_cs); end
      if (m_cs) begin
        if (first_cs < 0) first_cs = n;
        checks++; if (fired !== 4'b0101) begin errors++; $display("FAIL win_fired w=%0d got %b exp 0101", win, fired); end
        checks++; if (actual_phase[7:0] !== 8'd3) begin errors++; $display("FAIL win_ph0 got %0d exp 3", actual_phase[7:0]); end
        checks++; if (actual_phase[15:8] !== 8'd0) begin errors++; $display("FAIL win_ph1 got %0d exp 0", actual_phase[15:8]); end
        checks++; if (actual_phase[23:16] !== ((win == 0) ? 8'd15 : 8'd0)) begin
          errors++; $display("FAIL win_ph2 w=%0d got %0d exp %0d", win, actual_phase[23:16], (win == 0) ? 15 : 0); end
        win++;
      end
    end
    checks++; if (first_cs != 17) begin errors++; $display("FAIL win_first_cs got %0d exp 17", first_cs); end
    checks++; if (win != 2) begin errors++; $display("FAIL win_count got %0d exp 2", win); end
  endtask

  task automatic test_disable();
    int n, cs_seen;
    do_reset();
    enable = 1'b1;
    for (n = 0; n < 40 && !(m_run && m_phase == 5); n++) cyc();
    checks++; if (!(m_run && m_phase == 5)) begin errors++; $display("FAIL dis_reach got %0d exp 5", m_phase); end
    enable = 1'b0; cs_seen = 0;
    for (n = 0; n < 30; n++) begin
      spike_in = 4'(n);
      cyc();
      if (cycle_start === 1'b1) cs_seen++;
      checks++; if (busy !== m_run) begin errors++; $display("FAIL dis_busy n=%0d got %b exp %b", n, busy, m_run); end
    end
    spike_in = '0;
    checks++; if (cs_seen != 1) begin errors++; $display("FAIL dis_cs_count got %0d exp 1", cs_seen); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dis_idle got %b exp 0", busy); end
  endtask

  task automatic test_inject_rr();
    int n;
    do_reset();
    l2_wr_ready = 1'b1;
    force_pred_in = {8'd7, 8'd0, 8'd42, 8'd0};
    force_valid_in = 4'b1010;
    for (n = 0; n < 10 && l2_wr_valid !== 1'b1; n++) cyc();
    checks++; if (l2_wr_valid !== 1'b1 || l2_wr_sel !== 2'd1 || l2_wr_data !== 8'd42) begin
      errors++; $display("FAIL rr_first got v=%b s=%0d d=%0d exp 1/1/42", l2_wr_valid, l2_wr_sel, l2_wr_data); end
    cyc();
    for (n = 0; n < 10 && l2_wr_valid !== 1'b1; n++) cyc();
    checks++; if (l2_wr_valid !== 1'b1 || l2_wr_sel !== 2'd3 || l2_wr_data !== 8'd7) begin
      errors++; $display("FAIL rr_second got v=%b s=%0d d=%0d exp 1/3/7", l2_wr_valid, l2_wr_sel, l2_wr_data); end
    cyc();
    checks++; if (l2_wr_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got %b exp 0", l2_wr_valid); end
    checks++; if (grant_cnt !== (STATS ? 16'd2 : 16'd0)) begin
      errors++; $display("FAIL rr_grants got %0d exp %0d", grant_cnt, STATS ? 2 : 0); end
  endtask

  task automatic test_hold_overwrite();
    int n;
    force_valid_in = '0; l2_wr_ready = 1'b0;
    cyc(); cyc();
    force_pred_in = {8'd0, 8'd0, 8'd42, 8'd0}; force_valid_in = 4'b0010;
    for (n = 0; n < 10 && l2_wr_valid !== 1'b1; n++) cyc();
    force_valid_in = '0; cyc();
    force_pred_in = {8'd0, 8'd0, 8'd50, 8'd0}; force_valid_in = 4'b0010;
    cyc(); cyc();
    checks++; if (l2_wr_valid !== 1'b1 || l2_wr_sel !== 2'd1 || l2_wr_data !== 8'd42) begin
      errors++; $display("FAIL hold_stable got v=%b s=%0d d=%0d exp 1/1/42", l2_wr_valid, l2_wr_sel, l2_wr_data); end
    l2_wr_ready = 1'b1; cyc();
    l2_wr_ready = 1'b0; force_valid_in = '0;
    for (n = 0; n < 10 && l2_wr_valid !== 1'b1; n++) cyc();
    checks++; if (l2_wr_valid !== 1'b1 || l2_wr_sel !== 2'd1 || l2_wr_data !== 8'd50) begin
      errors++; $display("FAIL hold_shadow got v=%b s=%0d d=%0d exp 1/1/50", l2_wr_valid, l2_wr_sel, l2_wr_data); end
    force_pred_in = {8'd0, 8'd11, 8'd0, 8'd0}; force_valid_in = 4'b0100; cyc();
    force_valid_in = '0; cyc();
    force_pred_in = {8'd0, 8'd12, 8'd0, 8'd0}; force_valid_in = 4'b0100; cyc(); cyc();
    checks++; if (ovf_cnt !== (STATS ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL ovf_count got %0d exp %0d", ovf_cnt, STATS ? 1 : 0); end
    l2_wr_ready = 1'b1; cyc();
    for (n = 0; n < 10 && l2_wr_valid !== 1'b1; n++) cyc();
    checks++; if (l2_wr_valid !== 1'b1 || l2_wr_sel !== 2'd2 || l2_wr_data !== 8'd12) begin
      errors++; $display("FAIL ovf_data got v=%b s=%0d d=%0d exp 1/2/12", l2_wr_valid, l2_wr_sel, l2_wr_data); end
    cyc();
    checks++; if (grant_cnt !== (STATS ? 16'd5 : 16'd0)) begin
      errors++; $display("FAIL hold_grants got %0d exp %0d", grant_cnt, STATS ? 5 : 0); end
  endtask

  task automatic test_random();
    logic [SW-1:0] esel;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      enable = (((n / 45) % 4) != 3);
      for (int i = 0; i < N; i++) begin
        spike_in[i] = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 3) == 0) force_valid_in[i] = ~force_valid_in[i];
      end
      force_pred_in = 32'($urandom);
      l2_wr_ready = $urandom_range(0, 1) == 1;
      cyc();
      checks++; if (cycle_start !== m_cs || busy !== m_run || l2_wr_valid !== m_valid) begin
        errors++; $display("FAIL rnd_ctrl n=%0d got cs=%b busy=%b v=%b exp %b %b %b",
                           n, cycle_start, busy, l2_wr_valid, m_cs, m_run, m_valid); end
      if (m_valid) begin
        esel = SW'(m_sel);
        checks++; if (l2_wr_sel !== esel || l2_wr_data !== 8'(m_data)) begin
          errors++; $display("FAIL rnd_port n=%0d got s=%0d d=%0d exp s=%0d d=%0d", n, l2_wr_sel, l2_wr_data, m_sel, m_data); end
      end
      if (m_cs) begin
        checks++; if (fired !== m_fired) begin errors++; $display("FAIL rnd_fired n=%0d got %b exp %b", n, fired, m_fired); end
        for (int i = 0; i < N; i++) begin
          checks++; if (actual_phase[8*i +: 8] !== 8'(m_aph[i])) begin
            errors++; $display("FAIL rnd_phase n=%0d ch=%0d got %0d exp %0d", n, i, actual_phase[8*i +: 8], m_aph[i]); end
        end
      end
      checks++; if (grant_cnt !== (STATS ? 16'(m_grants) : 16'd0) || ovf_cnt !== (STATS ? 16'(m_ovf) : 16'd0)) begin
        errors++; $display("FAIL rnd_cnt n=%0d got g=%0d o=%0d exp g=%0d o=%0d", n, grant_cnt, ovf_cnt,
                           STATS ? m_grants : 0, STATS ? m_ovf : 0); end
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    do_reset();
    enable = 1'b1; l2_wr_ready = 1'b0;
    force_pred_in = {8'd0, 8'd9, 8'd8, 8'd0}; force_valid_in = 4'b0110;
    for (int n = 0; n < 10; n++) cyc();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (cycle_start !== 1'b0 || busy !== 1'b0 || l2_wr_valid !== 1'b0 || l2_wr_data !== 8'd0 || l2_wr_sel !== '0) begin
      errors++; $display("FAIL mid_reset got cs=%b busy=%b v=%b s=%0d d=%0d exp 0",
                         cycle_start, busy, l2_wr_valid, l2_wr_sel, l2_wr_data); end
    checks++; if (fired !== '0 || actual_phase !== '0 || grant_cnt !== 16'd0 || ovf_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_reset_data got f=%b p=%h g=%0d o=%0d exp 0", fired, actual_phase, grant_cnt, ovf_cnt); end
    enable = 1'b0; force_valid_in = '0;
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      cyc();
      if (cycle_start !== 1'b0 || l2_wr_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_quiet got %0d events exp 0", bad); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_window();
    test_disable();
    test_inject_rr();
    test_hold_overwrite();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
